// File: rtl/paced_cipher_ctrl.sv
// Paces an iterative block-cipher core with a one-cycle step strobe every DIV clocks,
// with valid/ready on both sides. Optional result cross-check: PACER_CHECK_EN.
module paced_cipher_ctrl #(
    parameter int unsigned BLOCK_W = 64,
    parameter int unsigned KEY_W   = 128,
    parameter int unsigned DIV     = 10,
    parameter int unsigned ROUNDS  = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_block,
    input  logic [KEY_W-1:0]   in_key,
    input  logic               in_mode,
    output logic               core_step,
    output logic               core_load,
    output logic [BLOCK_W-1:0] core_block,
    output logic [KEY_W-1:0]   core_key,
    output logic               core_mode,
    input  logic [BLOCK_W-1:0] core_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block,
`ifdef PACER_CHECK_EN
    input  logic [BLOCK_W-1:0] ref_result,
    output logic               mismatch,
    output logic [7:0]         err_cnt,
`endif
    output logic               busy
);

    localparam int unsigned DIV_W  = $clog2(DIV);
    localparam int unsigned STEP_W = $clog2(ROUNDS + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DIV_W-1:0]    div_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic                accept;
    logic                strobe;
    logic                last_strobe;
    logic                capture;
    logic                out_hs;

    // rst_n gates in_ready so nothing is offered while reset is held
    assign in_ready    = ena & rst_n & (state_q == ST_IDLE);
    assign accept      = in_ready & in_valid;
    assign strobe      = ena & (state_q == ST_RUN) & (div_cnt == DIV_LAST);
    assign last_strobe = strobe & (step_cnt == STEP_LAST);
    assign capture     = ena & (state_q == ST_WAIT);
    assign out_hs      = ena & (state_q == ST_DONE) & out_valid & out_ready;

    assign core_step   = strobe;
    assign core_load   = strobe & (step_cnt == '0);
    assign busy        = (state_q != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)      state_d = ST_RUN;
            ST_RUN:  if (last_strobe) state_d = ST_WAIT;
            ST_WAIT: if (ena)         state_d = ST_DONE;
            ST_DONE: if (out_hs)      state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Clock divider and step counter; both frozen while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            step_cnt <= '0;
        end else if (ena) begin
            if (accept) begin
                div_cnt  <= '0;
                step_cnt <= '0;
            end else if (state_q == ST_RUN) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
                if (strobe) begin
                    step_cnt <= step_cnt + STEP_W'(1);
                end
            end
        end
    end

    // Core operand registers, held for the whole run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_block <= '0;
            core_key   <= '0;
            core_mode  <= 1'b0;
        end else if (accept) begin
            core_block <= in_block;
            core_key   <= in_key;
            core_mode  <= in_mode;
        end
    end

    // Result capture and output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_block <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_block <= core_result;
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PACER_CHECK_EN
    // Sticky compare against the reference, counted with saturation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else if (capture && (ref_result != core_result)) begin
            mismatch <= 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_paced_cipher_ctrl.sv
// Self-checking bench for paced_cipher_ctrl: default-parameter instance plus a DIV=2/ROUNDS=1 instance.
module tb_paced_cipher_ctrl;

    typedef struct {
        logic [63:0]  block;
        logic [127:0] key;
        logic         mode;
        int           hold;
        int           gap_at;
        int           gap_len;
        int           exp_first;
        int           exp_last;
        int           exp_lat;
        int           exp_ii;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, ena;
    logic         in_valid, in_ready, in_mode;
    logic [63:0]  in_block;
    logic [127:0] in_key;
    logic         core_step, core_load, core_mode;
    logic [63:0]  core_block, core_res, out_block;
    logic [127:0] core_key;
    logic         out_valid, out_ready, busy;

    logic         s_in_valid, s_in_ready, s_in_mode;
    logic [63:0]  s_in_block;
    logic [127:0] s_in_key;
    logic         s_core_step, s_core_load, s_core_mode;
    logic [63:0]  s_core_block, s_core_res, s_out_block;
    logic [127:0] s_core_key;
    logic         s_out_valid, s_out_ready, s_busy;

`ifdef PACER_CHECK_EN
    logic         mismatch, s_mismatch;
    logic [7:0]   err_cnt, s_err_cnt;
    logic [63:0]  s_corrupt;
    logic [63:0]  s_ref;
    assign s_ref = s_core_res ^ s_corrupt;
`endif

    paced_cipher_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .in_key(in_key), .in_mode(in_mode),
        .core_step(core_step), .core_load(core_load), .core_block(core_block),
        .core_key(core_key), .core_mode(core_mode), .core_result(core_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
`ifdef PACER_CHECK_EN
        .ref_result(core_res), .mismatch(mismatch), .err_cnt(err_cnt),
`endif
        .busy(busy)
    );

    paced_cipher_ctrl #(.DIV(2), .ROUNDS(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_block(s_in_block),
        .in_key(s_in_key), .in_mode(s_in_mode),
        .core_step(s_core_step), .core_load(s_core_load), .core_block(s_core_block),
        .core_key(s_core_key), .core_mode(s_core_mode), .core_result(s_core_res),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_block(s_out_block),
`ifdef PACER_CHECK_EN
        .ref_result(s_ref), .mismatch(s_mismatch), .err_cnt(s_err_cnt),
`endif
        .busy(s_busy)
    );

    // Toy iterative cipher core: load mixes in a mode-selected key half, each further step rotates and mixes.
    always @(posedge clk) begin
        if (core_step)
            core_res <= core_load ? (core_block ^ (core_mode ? core_key[63:0] : core_key[127:64]))
                                  : ({core_res[62:0], core_res[63]} ^ core_key[63:0]);
        if (s_core_step)
            s_core_res <= s_core_load ? (s_core_block ^ (s_core_mode ? s_core_key[63:0] : s_core_key[127:64]))
                                      : ({s_core_res[62:0], s_core_res[63]} ^ s_core_key[63:0]);
    end

    function automatic logic [63:0] model_res(input logic [63:0] b, input logic [127:0] k,
                                              input logic m, input int rounds);
        logic [63:0] r;
        r = b ^ (m ? k[63:0] : k[127:64]);
        for (int i = 1; i < rounds; i++) r = {r[62:0], r[63]} ^ k[63:0];
        return r;
    endfunction

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] s_exp_q[$];
    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One block through the default instance: accept, watch strobes, hold output, handshake.
    task automatic run_block(input vec_t v, output int acc_cyc);
        int n, steps, loads, first, last, load_edge, lat, off_steps;
        logic [63:0] b0;
        n = 0;
        while (!in_ready && n < 300) begin tick(); n++; end
        check("accept_ready", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_block  = v.block;
        in_key    = v.key;
        in_mode   = v.mode;
        out_ready = (v.hold == 0);
        exp_q.push_back(model_res(v.block, v.key, v.mode, 9));
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_block = {$urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        in_mode  = ~v.mode;
        steps = 0; loads = 0; first = 0; last = 0; load_edge = 0; lat = 0; off_steps = 0;
        for (int k = 0; k < 300; k++) begin
            if (core_step) begin
                steps++;
                if (first == 0) first = k + 1;
                last = k + 1;
                if (!ena) off_steps++;
            end
            if (core_load) begin
                loads++;
                load_edge = k + 1;
            end
            if (out_valid) begin
                lat = k;
                break;
            end
            if (v.gap_len > 0 && k == v.gap_at) ena = 1'b0;
            if (v.gap_len > 0 && k == v.gap_at + v.gap_len) ena = 1'b1;
            tick();
        end
        ena = 1'b1;
        check("step_count", 64'(steps), 64'd9);
        check("load_count", 64'(loads), 64'd1);
        check("load_edge", 64'(load_edge), 64'(v.exp_first));
        check("first_step", 64'(first), 64'(v.exp_first));
        check("last_step", 64'(last), 64'(v.exp_last));
        check("latency", 64'(lat), 64'(v.exp_lat));
        check("step_while_off", 64'(off_steps), 64'd0);
        b0 = out_block;
        for (int j = 0; j < v.hold; j++) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_block", out_block, b0);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        check("out_valid_hs", 64'(out_valid), 64'd1);
        if (exp_q.size() > 0) check("out_block", out_block, exp_q.pop_front());
        else check("scoreboard_empty", 64'(exp_q.size()), 64'd1);
        tick();
        check("valid_cleared", 64'(out_valid), 64'd0);
        check("ready_after_hs", 64'(in_ready), 64'd1);
        check("busy_after_hs", 64'(busy), 64'd0);
    endtask

    // One block through the DIV=2/ROUNDS=1 instance with exact-edge checks.
    task automatic run_small(input logic [63:0] b, input logic [127:0] k, input logic m);
        int n;
        n = 0;
        while (!s_in_ready && n < 50) begin tick(); n++; end
        check("s_accept_ready", 64'(s_in_ready), 64'd1);
        s_in_valid = 1'b1;
        s_in_block = b;
        s_in_key   = k;
        s_in_mode  = m;
        s_exp_q.push_back(model_res(b, k, m, 1));
        tick();
        s_in_valid = 1'b0;
        check("s_step_e1", 64'(s_core_step), 64'd0);
        tick();
        check("s_step_e2", 64'(s_core_step), 64'd1);
        check("s_load_e2", 64'(s_core_load), 64'd1);
        tick();
        check("s_step_after", 64'(s_core_step), 64'd0);
        check("s_valid_early", 64'(s_out_valid), 64'd0);
        tick();
        check("s_valid_e3", 64'(s_out_valid), 64'd1);
        if (s_exp_q.size() > 0) check("s_out_block", s_out_block, s_exp_q.pop_front());
        tick();
        check("s_valid_cleared", 64'(s_out_valid), 64'd0);
        check("s_ready_after", 64'(s_in_ready), 64'd1);
    endtask

    initial begin
        int acc, prev_acc;
        vecs[0] = '{64'h0123_4567_89AB_CDEF, 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, 1'b1,  0,  0, 0, 10, 90, 91,   0};
        vecs[1] = '{64'hDEAD_BEEF_CAFE_F00D, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 20,  0, 0, 10, 90, 91,  93};
        vecs[2] = '{64'hFFFF_0000_FFFF_0000, 128'hA5A5_A5A5_5A5A_5A5A_0000_FFFF_1234_5678, 1'b1,  0, 45, 5, 10, 95, 96, 113};
        vecs[3] = '{64'h8000_0000_0000_0001, 128'h0000_0000_0000_0001_8000_0000_0000_0000, 1'b0,  3,  0, 0, 10, 90, 91,  98};

        rst_n = 1'b0; ena = 1'b1;
        in_valid = 1'b0; in_block = '0; in_key = '0; in_mode = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_block = '0; s_in_key = '0; s_in_mode = 1'b0; s_out_ready = 1'b1;
`ifdef PACER_CHECK_EN
        s_corrupt = '0;
`endif
        repeat (2) tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            run_block(vecs[i], acc);
            if (vecs[i].exp_ii != 0) check("init_interval", 64'(acc - prev_acc), 64'(vecs[i].exp_ii));
            prev_acc = acc;
        end

        // Reset in the middle of a run discards the block
        while (!in_ready) tick();
        in_valid = 1'b1; in_block = 64'h5555_AAAA_1234_9876; in_key = 128'h1; in_mode = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (44) tick();
        check("mid_run_busy", 64'(busy), 64'd1);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_in_ready", 64'(in_ready), 64'd0);
        check("mr_core_step", 64'(core_step), 64'd0);
        check("mr_core_load", 64'(core_load), 64'd0);
        check("mr_core_block", core_block, 64'd0);
        check("mr_core_key_lo", core_key[63:0], 64'd0);
        check("mr_core_key_hi", core_key[127:64], 64'd0);
        check("mr_core_mode", 64'(core_mode), 64'd0);
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_out_block", out_block, 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("mr_release_ready", 64'(in_ready), 64'd1);
        check("mr_release_busy", 64'(busy), 64'd0);
        run_block(vecs[0], acc);

        run_small(64'h0F0F_0F0F_F0F0_F0F0, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF, 1'b1);
        run_small(64'h1357_9BDF_2468_ACE0, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 1'b0);

`ifdef PACER_CHECK_EN
        check("mm_clean", 64'(mismatch), 64'd0);
        check("s_mm_init", 64'(s_mismatch), 64'd0);
        s_corrupt = 64'h1;
        run_small(64'h1, 128'h2, 1'b1);
        run_small(64'h3, 128'h4, 1'b0);
        s_corrupt = '0;
        run_small(64'h5, 128'h6, 1'b1);
        check("s_mm_two", 64'(s_mismatch), 64'd1);
        check("s_err_two", 64'(s_err_cnt), 64'd2);
        s_corrupt = 64'h8000_0000_0000_0000;
        for (int i = 0; i < 298; i++) run_small(64'(i), 128'(i * 7), i[0]);
        check("s_err_sat", 64'(s_err_cnt), 64'd255);
        check("s_mm_sticky", 64'(s_mismatch), 64'd1);
`endif

        check("scoreboard_drained", 64'(exp_q.size() + s_exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
